// File: rtl/mul_div_seq_if.sv
// mul_div_seq_if: request/result bundle between the instruction decoder
// and the iterative multiply/divide sequencer.
//   master (decoder) drives: start, op[1:0], a, b
//   slave (sequencer) drives: busy, done, rl, rh, zf, cf, dz
interface mul_div_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rl;
  logic [WIDTH-1:0] rh;
  logic             zf;
  logic             cf;
  logic             dz;

  modport master (
    output start, op, a, b,
    input  busy, done, rl, rh, zf, cf, dz
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, rl, rh, zf, cf, dz
  );
endinterface

// File: rtl/mul_div_seq.sv
// mul_div_seq: iterative WIDTH-bit multiply/divide sequencer for the
// MUL REG,REG and DIV REG,REG execute steps. One result bit per clock:
// shift-add multiply, restoring divide.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-low reset
//   bus   - mul_div_seq_if.slave: start/op/a/b in, busy/done/rl/rh/zf/cf/dz out
//           op[0]: 0 = MUL, 1 = DIV; op[1]: signed select
// Optional feature: define MULDIV_SIGNED_EN to honour op[1] (two's-complement
// operands, magnitude datapath plus a one-cycle FIX sign correction).
module mul_div_seq #(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         reset,
  mul_div_seq_if.slave bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int AW    = 2*WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] n;
    n = -v;
    return v[WIDTH-1] ? $unsigned(n) : $unsigned(v);
  endfunction

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             is_div, sgn, neg_a, neg_b, ovf;
  logic [WIDTH-1:0] opnd, opnd_nxt;
  logic [AW-1:0]    acc, acc_nxt, sh;
  logic [WIDTH:0]   sum, trial;
  logic             accept, load_out, need_fix;
  logic             sgn_in, dz_in, ovf_in;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] res_lo, res_hi;
  logic             zf_nxt, cf_nxt;
  logic [WIDTH-1:0] rl_q, rh_q;
  logic             zf_q, cf_q, dz_q;

`ifdef MULDIV_SIGNED_EN
  assign sgn_in   = bus.op[1];
  // Product is negated when signs differ; quotient likewise, remainder
  // follows the dividend. The most-negative/-1 overflow skips correction.
  assign need_fix = sgn && !ovf && ((neg_a ^ neg_b) || (is_div && neg_a));
`else
  // op[1] has no effect without signed support.
  assign sgn_in   = bus.op[1] & 1'b0;
  assign need_fix = 1'b0;
`endif

  assign accept = bus.start && (state == IDLE || state == DONE);
  assign dz_in  = bus.op[0] && (bus.b == '0);
  assign ovf_in = sgn_in && bus.op[0] && (bus.a == {1'b1, {(WIDTH-1){1'b0}}})
                  && (bus.b == {WIDTH{1'b1}});
  assign mag_a  = sgn_in ? mag(bus.a) : bus.a;
  assign mag_b  = sgn_in ? mag(bus.b) : bus.b;

  // Multiply step: add operand into the upper half; divide step: shift then
  // trial-subtract, borrow shows up in the extra top bit.
  assign sum   = acc[AW-1:WIDTH] + {1'b0, opnd};
  assign sh    = {acc[AW-2:0], 1'b0};
  assign trial = sh[AW-1:WIDTH] - {1'b0, opnd};

  always_comb begin
    acc_nxt  = acc;
    opnd_nxt = opnd;
    if (accept) begin
      if (dz_in) begin
        acc_nxt = {1'b0, bus.a, {WIDTH{1'b1}}};
      end else begin
        acc_nxt  = {{(WIDTH+1){1'b0}}, bus.op[0] ? mag_a : mag_b};
        opnd_nxt = bus.op[0] ? mag_b : mag_a;
      end
    end else if (state == RUN) begin
      if (!is_div) begin
        acc_nxt = {1'b0, acc[0] ? sum : acc[AW-1:WIDTH], acc[WIDTH-1:1]};
      end else if (!trial[WIDTH]) begin
        acc_nxt = {trial, sh[WIDTH-1:1], 1'b1};
      end else begin
        acc_nxt = sh;
      end
    end else if (state == FIX) begin
      if (!is_div) begin
        acc_nxt[2*WIDTH-1:0] = -acc[2*WIDTH-1:0];
      end else begin
        if (neg_a ^ neg_b) acc_nxt[WIDTH-1:0] = -acc[WIDTH-1:0];
        if (neg_a) acc_nxt[2*WIDTH-1:WIDTH] = -acc[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
    case (state)
      RUN: begin
        if (cnt == LAST) begin
          state_nxt = need_fix ? FIX : DONE;
          load_out  = !need_fix;
        end
      end
      FIX: begin
        state_nxt = DONE;
        load_out  = 1'b1;
      end
      default: begin
        state_nxt = (state == DONE) ? IDLE : state;
        if (accept) begin
          state_nxt = dz_in ? DONE : RUN;
          load_out  = dz_in;
        end
      end
    endcase
  end

  assign res_lo = acc_nxt[WIDTH-1:0];
  assign res_hi = acc_nxt[2*WIDTH-1:WIDTH];
  assign zf_nxt = is_div ? (res_lo == '0) : ({res_hi, res_lo} == '0);
  assign cf_nxt = is_div ? ovf
                : (sgn ? (res_hi != {WIDTH{res_lo[WIDTH-1]}}) : (res_hi != '0));

  // Control state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      sgn    <= 1'b0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt    <= '0;
        is_div <= bus.op[0];
        sgn    <= sgn_in;
        neg_a  <= sgn_in & bus.a[WIDTH-1];
        neg_b  <= sgn_in & bus.b[WIDTH-1];
        ovf    <= ovf_in;
      end else if (state == RUN) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Datapath
  always_ff @(posedge clk) begin
    acc  <= acc_nxt;
    opnd <= opnd_nxt;
  end

  // Result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rl_q <= '0;
      rh_q <= '0;
      zf_q <= 1'b0;
      cf_q <= 1'b0;
      dz_q <= 1'b0;
    end else if (load_out && accept) begin
      rl_q <= res_lo;
      rh_q <= res_hi;
      zf_q <= 1'b0;
      cf_q <= 1'b0;
      dz_q <= 1'b1;
    end else if (load_out) begin
      rl_q <= res_lo;
      rh_q <= res_hi;
      zf_q <= zf_nxt;
      cf_q <= cf_nxt;
      dz_q <= 1'b0;
    end else if (accept) begin
      zf_q <= 1'b0;
      cf_q <= 1'b0;
      dz_q <= 1'b0;
    end
  end

  assign bus.busy = (state == RUN) || (state == FIX);
  assign bus.done = (state == DONE);
  assign bus.rl   = rl_q;
  assign bus.rh   = rh_q;
  assign bus.zf   = zf_q;
  assign bus.cf   = cf_q;
  assign bus.dz   = dz_q;
endmodule

// File: tb/tb_mul_div_seq.sv
// tb_mul_div_seq: bench for mul_div_seq (WIDTH = 8). Directed vector table,
// hand-written multi-cycle sequences and random operations checked against
// an arithmetic reference model. Signed vectors are added when
// MULDIV_SIGNED_EN is defined.
module tb_mul_div_seq;
  logic clk;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;

  mul_div_seq_if #(.WIDTH(8)) bus ();
  mul_div_seq #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a, b;
    logic [7:0] rl, rh;
    logic       zf, cf, dz;
    int         lat;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: plain integer arithmetic from the operation rules.
  task automatic model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] rl, output logic [7:0] rh,
                       output logic zf, output logic cf, output logic dz, output int lat);
    int sa, sb, p, q, r;
    logic sg;
    sg = 1'b0;
`ifdef MULDIV_SIGNED_EN
    sg = op[1];
`endif
    if (sg) begin sa = int'($signed(a)); sb = int'($signed(b)); end
    else begin sa = int'(a); sb = int'(b); end
    dz = 1'b0; cf = 1'b0; lat = 9;
    if (!op[0]) begin
      p  = sa * sb;
      rl = p[7:0]; rh = p[15:8];
      zf = (p == 0);
      cf = sg ? (p < -128 || p > 127) : (p > 255);
      if (sg && ((sa < 0) != (sb < 0))) lat = 10;
    end else if (b == 8'h00) begin
      rl = 8'hFF; rh = a; zf = 1'b0; dz = 1'b1; lat = 1;
    end else if (sg && sa == -128 && sb == -1) begin
      rl = 8'h80; rh = 8'h00; zf = 1'b0; cf = 1'b1;
    end else begin
      q  = sa / sb; r = sa % sb;
      rl = q[7:0]; rh = r[7:0];
      zf = (q == 0);
      if (sg && (((sa < 0) != (sb < 0)) || sa < 0)) lat = 10;
    end
  endtask

  // Issue one operation; optionally pulse a stray DIV-by-zero start at
  // wait cycle inject_at. Returns at the first cycle with done high.
  task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int inject_at,
                        output logic [7:0] rl, output logic [7:0] rh,
                        output logic zf, output logic cf, output logic dz,
                        output int lat, output int nb);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    tick();
    bus.start = 1'b0;
    lat = 1; nb = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) nb++;
      if (lat == inject_at) begin
        bus.start = 1'b1; bus.op = 2'b01; bus.a = 8'h55; bus.b = 8'h00;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      lat++;
    end
    bus.start = 1'b0;
    rl = bus.rl; rh = bus.rh; zf = bus.zf; cf = bus.cf; dz = bus.dz;
  endtask

  task automatic check_res(input string nm, input logic [7:0] rl, input logic [7:0] rh,
                           input logic zf, input logic cf, input logic dz, input int lat,
                           input logic [7:0] erl, input logic [7:0] erh,
                           input logic ezf, input logic ecf, input logic edz, input int elat);
    chk({nm, ".rl"}, 32'(rl), 32'(erl));
    chk({nm, ".rh"}, 32'(rh), 32'(erh));
    chk({nm, ".flags"}, 32'({zf, cf, dz}), 32'({ezf, ecf, edz}));
    chk({nm, ".lat"}, 32'(lat), 32'(elat));
  endtask

  initial begin
    vec_t       vt[$];
    logic [7:0] rl, rh, erl, erh, ra, rb;
    logic       zf, cf, dz, ezf, ecf, edz;
    logic [1:0] rop;
    int         lat, nb, elat;

    vt.push_back('{2'b00, 8'd13, 8'd11, 8'h8F, 8'h00, 1'b0, 1'b0, 1'b0, 9});
    vt.push_back('{2'b00, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b1, 1'b0, 9});
    vt.push_back('{2'b00, 8'h00, 8'h37, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 9});
    vt.push_back('{2'b01, 8'd200, 8'd7, 8'h1C, 8'h04, 1'b0, 1'b0, 1'b0, 9});
    vt.push_back('{2'b01, 8'h55, 8'h00, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b1, 1});
    vt.push_back('{2'b01, 8'd5, 8'd9, 8'h00, 8'h05, 1'b1, 1'b0, 1'b0, 9});
    vt.push_back('{2'b01, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 9});
`ifdef MULDIV_SIGNED_EN
    vt.push_back('{2'b10, 8'hF9, 8'h03, 8'hEB, 8'hFF, 1'b0, 1'b0, 1'b0, 10});
    vt.push_back('{2'b11, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0, 1'b0, 10});
    vt.push_back('{2'b11, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 9});
`else
    vt.push_back('{2'b10, 8'hF9, 8'h03, 8'hEB, 8'h02, 1'b0, 1'b1, 1'b0, 9});
`endif

    reset = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = 8'h00; bus.b = 8'h00;
    tick(); tick();
    chk("reset.busy_done", 32'({bus.busy, bus.done}), 32'd0);
    chk("reset.outs", 32'({bus.rl, bus.rh, bus.zf, bus.cf, bus.dz}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Directed table
    foreach (vt[i]) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, -1, rl, rh, zf, cf, dz, lat, nb);
      check_res($sformatf("vec%0d", i), rl, rh, zf, cf, dz, lat,
                vt[i].rl, vt[i].rh, vt[i].zf, vt[i].cf, vt[i].dz, vt[i].lat);
      chk($sformatf("vec%0d.busy_cycles", i), 32'(nb), 32'(vt[i].lat - 1));
      tick();
      chk($sformatf("vec%0d.done_pulse", i), 32'({bus.done, bus.busy}), 32'd0);
    end

    // Back-to-back: second start issued in the DONE cycle
    run_op(2'b01, 8'd200, 8'd7, -1, rl, rh, zf, cf, dz, lat, nb);
    run_op(2'b00, 8'd3, 8'd5, -1, rl, rh, zf, cf, dz, lat, nb);
    check_res("b2b", rl, rh, zf, cf, dz, lat, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b0, 9);
    tick();

    // Stray start during RUN is ignored
    run_op(2'b00, 8'd13, 8'd11, 3, rl, rh, zf, cf, dz, lat, nb);
    check_res("ignore_start", rl, rh, zf, cf, dz, lat, 8'h8F, 8'h00, 1'b0, 1'b0, 1'b0, 9);
    tick();
    chk("ignore_start.idle", 32'({bus.done, bus.busy}), 32'd0);

    // Reset in RUN cycle 4 of MUL 0x12*0x34
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 8'h12; bus.b = 8'h34;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    chk("rst_mid.busy_before", 32'(bus.busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid.outs", 32'({bus.busy, bus.done, bus.rl, bus.rh, bus.zf, bus.cf, bus.dz}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    run_op(2'b00, 8'd3, 8'd5, -1, rl, rh, zf, cf, dz, lat, nb);
    check_res("after_rst", rl, rh, zf, cf, dz, lat, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b0, 9);

    // Random operations against the reference model
    for (int k = 0; k < 150; k++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = 8'($urandom_range(0, 255));
      rb  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      if (k < 4) begin ra = 8'h80; rb = 8'hFF; end
      model(rop, ra, rb, erl, erh, ezf, ecf, edz, elat);
      run_op(rop, ra, rb, -1, rl, rh, zf, cf, dz, lat, nb);
      check_res($sformatf("rnd%0d_op%0d_%0h_%0h", k, rop, ra, rb), rl, rh, zf, cf, dz, lat,
                erl, erh, ezf, ecf, edz, elat);
      if (k % 3 == 0) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
